// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// CTRL bit layout, scan FSM encoding and the idle display patterns.
package seg_scan_ctrl_pkg;

   localparam logic [7:0] OFF_DATA   = 8'h00;
   localparam logic [7:0] OFF_CTRL   = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h08;

   localparam int         CTRL_W         = 10;
   localparam int         CTRL_GEN_BIT   = 8;
   localparam int         CTRL_HWSEL_BIT = 9;
   localparam logic [9:0] CTRL_RESET     = 10'h1FF;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [7:0] ANODES_OFF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_e;

   // Merge a bus write into a 32-bit register, one byte lane per strobe bit.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// picosoc iomem bus as seen by one slave: the core drives the request,
// the slave returns a one-cycle ready with read data.
interface seg_scan_ctrl_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/seg_scan_ctrl_seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_hex_decode
   import seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Pure lookup of the glyph for each hex value.
   always_comb begin
      // NOTE: default assignment first so no path leaves seg_o unassigned (no latch).
      seg_o = SEG_BLANK;
      case (hex_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller on the picosoc iomem bus.
// Digits are shown round-robin for REFRESH_DIV cycles each, separated by
// BLANK_CYCLES of dark time to avoid ghosting between digits.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter logic [7:0] ADDR_HI      = 8'h04,
   parameter int         REFRESH_DIV  = 100_000,
   parameter int         BLANK_CYCLES = 100
) (
   input  logic             clk,
   input  logic             resetn,
   seg_scan_ctrl_if.slave   iomem,
   input  logic [3:0]       hw_code,
   output logic [7:0]       anodes,
   output logic [6:0]       seg,
   output logic [2:0]       scan_idx
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   // Bus-side registers.
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   // Scan-side registers.
   scan_state_e       state_q;
   logic [2:0]        idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        anodes_q;
   logic [6:0]        seg_q;
   logic [2:0]        scan_idx_q;

   logic              accept;
   logic [31:0]       ctrl_wr;
   logic [3:0]        nibble;
   logic [6:0]        dec_seg;
   logic              digit_on;
   logic              addr_unused;

   // Only the window byte and the register offset take part in decoding.
   assign addr_unused = ^{iomem.iomem_addr[23:8], ctrl_wr[31:CTRL_W]};

   // Request decode, register read mux and byte-lane write merge.
   always_comb begin
      accept  = iomem.iomem_valid && !ready_q && (iomem.iomem_addr[31:24] == ADDR_HI);
      ctrl_wr = apply_wstrb({{(32-CTRL_W){1'b0}}, ctrl_q}, iomem.iomem_wdata, iomem.iomem_wstrb);
      ready_d = accept;
      rdata_d = '0;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (accept) begin
         case (iomem.iomem_addr[7:0])
            OFF_DATA: begin
               rdata_d = data_q;
               data_d  = apply_wstrb(data_q, iomem.iomem_wdata, iomem.iomem_wstrb);
            end
            OFF_CTRL: begin
               rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
               ctrl_d  = ctrl_wr[CTRL_W-1:0];
            end
            OFF_STATUS: rdata_d = {28'b0, (state_q == ST_BLANK), idx_q};
            default:    rdata_d = '0;
         endcase
      end
   end

   // Bus-side state: ack pulse, captured read data and configuration.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: configuration registers are ordinary flops, so they all take reset values.
         ready_q <= 1'b0;
         rdata_q <= '0;
         data_q  <= '0;
         ctrl_q  <= CTRL_RESET;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign iomem.iomem_ready = ready_q;
   assign iomem.iomem_rdata = rdata_q;

   // Pick the nibble for the selected digit; digit 0 may follow hw_code instead.
   always_comb begin
      nibble = data_q[{idx_q, 2'b00} +: 4];
      if (idx_q == 3'd0 && ctrl_q[CTRL_HWSEL_BIT]) nibble = hw_code;
      digit_on = (state_q == ST_SHOW) && ctrl_q[CTRL_GEN_BIT] && ctrl_q[idx_q];
   end

   seg7_hex_decode u_decode (
      .hex_i (nibble),
      .seg_o (dec_seg)
   );

   // Scan FSM: dwell counter, digit index and the registered display outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_SHOW;
         idx_q      <= '0;
         cnt_q      <= '0;
         anodes_q   <= ANODES_OFF;
         seg_q      <= SEG_BLANK;
         scan_idx_q <= '0;
      end else begin
         anodes_q   <= digit_on ? ~(8'b1 << idx_q) : ANODES_OFF;
         seg_q      <= digit_on ? dec_seg : SEG_BLANK;
         scan_idx_q <= idx_q;
         if (!ctrl_q[CTRL_GEN_BIT]) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_SHOW;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
               ST_SHOW: begin
                  if (cnt_q == SHOW_LAST) begin
                     cnt_q   <= '0;
                     state_q <= ST_BLANK;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_BLANK: begin
                  if (cnt_q == BLANK_LAST) begin
                     cnt_q   <= '0;
                     idx_q   <= idx_q + 3'd1;
                     state_q <= ST_SHOW;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign anodes   = anodes_q;
   assign seg      = seg_q;
   assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=2:
// each digit slot is 4 shown cycles followed by 2 dark cycles.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] hw_code;
   logic [7:0] anodes;
   logic [6:0] seg;
   logic [2:0] scan_idx;

   int tests  = 0;
   int failed = 0;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .ADDR_HI      (8'h04),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .iomem    (bus),
      .hw_code  (hw_code),
      .anodes   (anodes),
      .seg      (seg),
      .scan_idx (scan_idx)
   );

   always #5 clk = ~clk;

   // Single bus access; holds valid until ready or the budget runs out.
   task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output bit seen,
                             output logic [31:0] rd);
      seen = 1'b0;
      rd   = '0;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = addr;
      bus.iomem_wdata = wdata;
      bus.iomem_wstrb = wstrb;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.iomem_ready) begin
            seen = 1'b1;
            rd   = bus.iomem_rdata;
            break;
         end
      end
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
   endtask

   task automatic wait_anodes(input logic [7:0] target, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (anodes === target) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #20;
      tests++; if (anodes !== 8'hFF) begin failed++; $display("FAIL reset_anodes: got %h expected ff", anodes); end
      tests++; if (seg !== 7'h7F) begin failed++; $display("FAIL reset_seg: got %h expected 7f", seg); end
      tests++; if (scan_idx !== 3'd0) begin failed++; $display("FAIL reset_scan_idx: got %0d expected 0", scan_idx); end
      tests++; if (bus.iomem_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b expected 0", bus.iomem_ready); end
      tests++; if (bus.iomem_rdata !== 32'h0) begin failed++; $display("FAIL reset_rdata: got %h expected 0", bus.iomem_rdata); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_scan_sequence;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      int d, q;
      for (int n = 1; n <= 50; n++) begin
         @(posedge clk); #1;
         d = ((n - 1) / 6) % 8;
         q = (n - 1) % 6;
         exp_an  = (q < 4) ? ~(8'h01 << d) : 8'hFF;
         exp_seg = (q < 4) ? 7'h40 : 7'h7F;
         tests++; if (anodes !== exp_an) begin failed++; $display("FAIL scan_anodes n=%0d: got %h expected %h", n, anodes, exp_an); end
         tests++; if (seg !== exp_seg) begin failed++; $display("FAIL scan_seg n=%0d: got %h expected %h", n, seg, exp_seg); end
         tests++; if (scan_idx !== 3'(d)) begin failed++; $display("FAIL scan_idx n=%0d: got %0d expected %0d", n, scan_idx, d); end
      end
   endtask

   task automatic test_data_write;
      bit seen, found;
      logic [31:0] rd;
      bus_access(32'h0400_0000, 32'h7654_3210, 4'hF, seen, rd);
      tests++; if (seen !== 1'b1) begin failed++; $display("FAIL data_write_ack: got %b expected 1", seen); end
      @(posedge clk); #1;
      tests++; if (bus.iomem_ready !== 1'b0) begin failed++; $display("FAIL data_ready_one_cycle: got %b expected 0", bus.iomem_ready); end
      wait_anodes(8'hDF, 60, found);
      tests++; if (!found) begin failed++; $display("FAIL digit5_timeout: got none expected anodes df"); end
      tests++; if (seg !== 7'h12) begin failed++; $display("FAIL digit5_seg: got %h expected 12", seg); end
      tests++; if (scan_idx !== 3'd5) begin failed++; $display("FAIL digit5_idx: got %0d expected 5", scan_idx); end
   endtask

   task automatic test_digit_enable;
      bit seen, saw_fe, saw_fb;
      logic [31:0] rd;
      saw_fe = 1'b0;
      saw_fb = 1'b0;
      bus_access(32'h0400_0004, 32'h0000_0105, 4'hF, seen, rd);
      tests++; if (seen !== 1'b1) begin failed++; $display("FAIL enable_write_ack: got %b expected 1", seen); end
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #1;
         if (anodes === 8'hFE) begin
            saw_fe = 1'b1;
            tests++; if (seg !== 7'h40) begin failed++; $display("FAIL enable_d0_seg: got %h expected 40", seg); end
         end else if (anodes === 8'hFB) begin
            saw_fb = 1'b1;
            tests++; if (seg !== 7'h24) begin failed++; $display("FAIL enable_d2_seg: got %h expected 24", seg); end
         end else begin
            tests++; if (anodes !== 8'hFF || seg !== 7'h7F) begin failed++; $display("FAIL enable_off_slot: got anodes %h seg %h expected ff 7f", anodes, seg); end
         end
      end
      tests++; if (!(saw_fe && saw_fb)) begin failed++; $display("FAIL enable_digits_seen: got fe=%b fb=%b expected 1 1", saw_fe, saw_fb); end
   endtask

   task automatic test_hw_override;
      bit seen, found;
      logic [31:0] rd;
      hw_code = 4'hA;
      bus_access(32'h0400_0004, 32'h0000_0305, 4'hF, seen, rd);
      tests++; if (seen !== 1'b1) begin failed++; $display("FAIL hwsel_write_ack: got %b expected 1", seen); end
      wait_anodes(8'hFB, 60, found);
      wait_anodes(8'hFE, 60, found);
      tests++; if (!found) begin failed++; $display("FAIL hwsel_timeout: got none expected anodes fe"); end
      tests++; if (seg !== 7'h08) begin failed++; $display("FAIL hwsel_seg_a: got %h expected 08", seg); end
      hw_code = 4'h3;
      @(posedge clk); #1;
      tests++; if (anodes !== 8'hFE || seg !== 7'h30) begin failed++; $display("FAIL hwsel_follow: got anodes %h seg %h expected fe 30", anodes, seg); end
      hw_code = 4'h0;
   endtask

   task automatic test_status_and_decode;
      bit seen, found;
      logic [31:0] rd;
      bus_access(32'h0400_0004, 32'h0000_01FF, 4'hF, seen, rd);
      wait_anodes(8'hF7, 60, found);
      wait_anodes(8'hFF, 10, found);
      tests++; if (!found) begin failed++; $display("FAIL status_timeout: got none expected blank after digit 3"); end
      bus_access(32'h0400_0008, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0000_000B) begin failed++; $display("FAIL status_blank: got ack %b rdata %h expected 1 0000000b", seen, rd); end
      bus_access(32'h0400_000C, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0) begin failed++; $display("FAIL unmapped_read: got ack %b rdata %h expected 1 00000000", seen, rd); end
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = 32'h0300_0000;
      bus.iomem_wdata = 32'hFFFF_FFFF;
      bus.iomem_wstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++; if (bus.iomem_ready !== 1'b0) begin failed++; $display("FAIL foreign_addr_ack cyc=%0d: got %b expected 0", i, bus.iomem_ready); end
      end
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
      bus_access(32'h0400_0000, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h7654_3210) begin failed++; $display("FAIL foreign_write_dropped: got ack %b rdata %h expected 1 76543210", seen, rd); end
   endtask

   task automatic test_byte_strobe_and_mask;
      bit seen;
      logic [31:0] rd;
      bus_access(32'h0400_0000, 32'hAAAA_BBAA, 4'b0010, seen, rd);
      bus_access(32'h0400_0000, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h7654_BB10) begin failed++; $display("FAIL byte_strobe: got ack %b rdata %h expected 1 7654bb10", seen, rd); end
      bus_access(32'h04AB_CD04, 32'hFFFF_FFFF, 4'hF, seen, rd);
      bus_access(32'h0400_0004, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0000_03FF) begin failed++; $display("FAIL ctrl_mask: got ack %b rdata %h expected 1 000003ff", seen, rd); end
      bus_access(32'h0400_0004, 32'h0000_01FF, 4'hF, seen, rd);
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = 32'h0400_0000;
      bus.iomem_wstrb = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         tests++; if (bus.iomem_ready !== ((i % 2) == 0)) begin failed++; $display("FAIL b2b_ready cyc=%0d: got %b expected %b", i, bus.iomem_ready, ((i % 2) == 0)); end
         if ((i % 2) == 0) begin
            tests++; if (bus.iomem_rdata !== 32'h7654_BB10) begin failed++; $display("FAIL b2b_rdata cyc=%0d: got %h expected 7654bb10", i, bus.iomem_rdata); end
         end
      end
      bus.iomem_valid = 1'b0;
   endtask

   task automatic test_global_disable;
      bit seen, found;
      logic [31:0] rd;
      wait_anodes(8'hEF, 60, found);
      tests++; if (!found) begin failed++; $display("FAIL disable_timeout: got none expected anodes ef"); end
      bus_access(32'h0400_0004, 32'h0000_00FF, 4'hF, seen, rd);
      @(posedge clk); #1;
      tests++; if (anodes !== 8'hFF || seg !== 7'h7F) begin failed++; $display("FAIL disable_blank: got anodes %h seg %h expected ff 7f", anodes, seg); end
      bus_access(32'h0400_0008, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0) begin failed++; $display("FAIL disable_status: got ack %b rdata %h expected 1 00000000", seen, rd); end
      tests++; if (scan_idx !== 3'd0) begin failed++; $display("FAIL disable_scan_idx: got %0d expected 0", scan_idx); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         tests++; if (anodes !== 8'hFF) begin failed++; $display("FAIL idle_anodes cyc=%0d: got %h expected ff", i, anodes); end
      end
      bus_access(32'h0400_0004, 32'h0000_01FF, 4'hF, seen, rd);
      @(posedge clk); #1;
      tests++; if (anodes !== 8'hFF) begin failed++; $display("FAIL reenable_idle_cycle: got %h expected ff", anodes); end
      @(posedge clk); #1;
      tests++; if (anodes !== 8'hFE || seg !== 7'h40) begin failed++; $display("FAIL reenable_first_digit: got anodes %h seg %h expected fe 40", anodes, seg); end
   endtask

   task automatic test_async_reset;
      bit seen, found;
      logic [31:0] rd;
      wait_anodes(8'hFD, 60, found);
      tests++; if (!found) begin failed++; $display("FAIL areset_timeout: got none expected anodes fd"); end
      bus_access(32'h0400_0004, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0000_01FF) begin failed++; $display("FAIL areset_pre_read: got ack %b rdata %h expected 1 000001ff", seen, rd); end
      #2 resetn = 1'b0;
      #1;
      tests++; if (anodes !== 8'hFF || seg !== 7'h7F || scan_idx !== 3'd0) begin failed++; $display("FAIL areset_outputs: got %h %h %0d expected ff 7f 0", anodes, seg, scan_idx); end
      tests++; if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin failed++; $display("FAIL areset_bus: got ready %b rdata %h expected 0 0", bus.iomem_ready, bus.iomem_rdata); end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      bus_access(32'h0400_0000, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0) begin failed++; $display("FAIL areset_data: got ack %b rdata %h expected 1 00000000", seen, rd); end
      bus_access(32'h0400_0004, 32'h0, 4'h0, seen, rd);
      tests++; if (!seen || rd !== 32'h0000_01FF) begin failed++; $display("FAIL areset_ctrl: got ack %b rdata %h expected 1 000001ff", seen, rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      hw_code         = 4'h0;
      bus.iomem_valid = 1'b0;
      bus.iomem_addr  = '0;
      bus.iomem_wdata = '0;
      bus.iomem_wstrb = 4'h0;
      test_reset();
      test_scan_sequence();
      test_data_write();
      test_digit_enable();
      test_hw_override();
      test_status_and_decode();
      test_byte_strobe_and_mask();
      test_back_to_back();
      test_global_disable();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
